// File: rtl/synth_pkg.sv
// Shared types, widths and helpers for the polyphonic square-wave synthesiser.
package synth_pkg;

    // Voice state is sized for the widest supported configuration; narrower ports zero-extend.
    localparam int VS_NOTE_W     = 8;
    localparam int VS_DUR_W      = 32;
    localparam int VS_CNT_W      = VS_NOTE_W + 15;
    localparam int DEF_AMPLITUDE = 10_000_000;

    typedef struct packed {
        logic [VS_NOTE_W-1:0] idx;
        logic [VS_DUR_W-1:0]  dur;
        logic [VS_CNT_W-1:0]  cnt;
        logic                 phase;
        logic                 active;
    } voice_state_t;

    typedef enum logic {WR_IDLE, WR_PENDING} wr_state_t;

    function automatic logic [VS_CNT_W-1:0] half_period(input logic [VS_NOTE_W-1:0] idx);
        return {idx, 15'd0} + VS_CNT_W'(3000);
    endfunction

endpackage

// File: rtl/synth_voice.sv
// One square-wave voice: half-period counter, phase, duration countdown and load/kill control.
module synth_voice import synth_pkg::*; #(
    parameter int NOTE_W = 4,
    parameter int DUR_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [NOTE_W-1:0] load_idx,
    input  logic [DUR_W-1:0]  load_dur,
    input  logic              kill,
    input  logic              tick,
    output logic              active,
    output logic              phase
);

    voice_state_t vs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vs <= '0;
        end else if (kill) begin
            vs.active <= 1'b0;
        end else if (load) begin
            // NOTE: sequential state uses <= so every voice samples the same pre-edge values.
            vs.idx    <= VS_NOTE_W'(load_idx);
            vs.dur    <= VS_DUR_W'(load_dur);
            vs.cnt    <= '0;
            vs.phase  <= 1'b1;
            vs.active <= 1'b1;
        end else if (vs.active) begin
            if (vs.cnt == half_period(vs.idx)) begin
                vs.cnt   <= '0;
                vs.phase <= ~vs.phase;
            end else begin
                vs.cnt <= vs.cnt + VS_CNT_W'(1);
            end
            // dur == 0 means sustain; the last counted tick still hears this voice.
            if (tick && vs.dur != '0) begin
                vs.dur <= vs.dur - VS_DUR_W'(1);
                if (vs.dur == VS_DUR_W'(1)) begin
                    vs.active <= 1'b0;
                end
            end
        end
    end

    assign active = vs.active;
    assign phase  = vs.phase;

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave generator: voice allocator, sample divider, saturating mixer
// and a paced single-sample write handshake towards the audio FIFO.
module poly_tone_synth import synth_pkg::*; #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 4,
    parameter int DUR_W      = 16,
    parameter int SAMPLE_W   = 32,
    parameter int AMPLITUDE  = DEF_AMPLITUDE,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                note_valid,
    input  logic [NOTE_W-1:0]   note_idx,
    input  logic [DUR_W-1:0]    note_dur,
    input  logic                all_off,
    input  logic                mute,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [NUM_VOICES-1:0] voices_active,
    output logic                sample_dropped
);

    localparam int MIX_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic signed [MIX_W-1:0]    AMP_POS = MIX_W'(AMPLITUDE);
    localparam logic signed [MIX_W-1:0]    AMP_NEG = -AMP_POS;
    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [DIV_W-1:0]          div;
    logic                      tick;
    logic [PTR_W-1:0]          alloc_ptr;
    logic                      trig;
    logic                      found;
    logic                      steal;
    logic [NUM_VOICES-1:0]     load;
    logic [NUM_VOICES-1:0]     v_active;
    logic [NUM_VOICES-1:0]     v_phase;
    logic signed [MIX_W-1:0]   mix;
    logic [SAMPLE_W-1:0]       sample_new;
    logic [SAMPLE_W-1:0]       buffer;
    wr_state_t                 state;

    assign tick = (div == DIV_W'(SAMPLE_DIV - 1));
    assign trig = note_valid && (note_idx != '0) && !all_off;

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        load  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!v_active[i] && !found) begin
                load[i] = 1'b1;
                found   = 1'b1;
            end
        end
        if (!found) begin
            load[alloc_ptr] = 1'b1;
        end
        if (!trig) begin
            load = '0;
        end
    end

    assign steal = trig && !found;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        synth_voice #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W)
        ) u_voice (
            .clk      (clk),
            .resetn   (resetn),
            .load     (load[i]),
            .load_idx (note_idx),
            .load_dur (note_dur),
            .kill     (all_off),
            .tick     (tick),
            .active   (v_active[i]),
            .phase    (v_phase[i])
        );
    end

    always_comb begin
        mix = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (v_active[i]) begin
                mix = mix + (v_phase[i] ? AMP_POS : AMP_NEG);
            end
        end
        if (mute) begin
            sample_new = '0;
        end else if (mix > MIX_W'(SAT_MAX)) begin
            sample_new = SAT_MAX;
        end else if (mix < MIX_W'(SAT_MIN)) begin
            sample_new = SAT_MIN;
        end else begin
            sample_new = mix[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div             <= '0;
            alloc_ptr       <= '0;
            state           <= WR_IDLE;
            buffer          <= '0;
            sample_out      <= '0;
            write_audio_out <= 1'b0;
            sample_dropped  <= 1'b0;
        end else begin
            div             <= tick ? '0 : div + DIV_W'(1);
            write_audio_out <= 1'b0;
            if (steal) begin
                alloc_ptr <= (alloc_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : alloc_ptr + PTR_W'(1);
            end
            if (tick) begin
                buffer <= sample_new;
            end
            // A free FIFO on the tick cycle takes the fresh sample straight through.
            case (state)
                WR_IDLE: begin
                    if (tick) begin
                        if (audio_out_allowed) begin
                            write_audio_out <= 1'b1;
                            sample_out      <= sample_new;
                        end else begin
                            state <= WR_PENDING;
                        end
                    end
                end
                WR_PENDING: begin
                    if (tick) begin
                        sample_dropped <= 1'b1;
                        if (audio_out_allowed) begin
                            write_audio_out <= 1'b1;
                            sample_out      <= sample_new;
                            state           <= WR_IDLE;
                        end
                    end else if (audio_out_allowed) begin
                        write_audio_out <= 1'b1;
                        sample_out      <= buffer;
                        state           <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    assign voices_active = v_active;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed bench for poly_tone_synth: a default 32-bit instance and a 24-bit instance
// driven in parallel so saturation is observed on the same voice activity.
module tb_poly_tone_synth;

    logic        clk;
    logic        resetn;
    logic        note_valid;
    logic [3:0]  note_idx;
    logic [15:0] note_dur;
    logic        all_off;
    logic        mute;
    logic        allowed;

    logic        a_write;
    logic [31:0] a_sample;
    logic [3:0]  a_active;
    logic        a_dropped;

    logic        b_write;
    logic [23:0] b_sample;
    logic [3:0]  b_active;
    logic        b_dropped;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    localparam longint AMP  = 10_000_000;
    localparam longint BMAX = 8_388_607;
    localparam longint BMIN = -8_388_608;

    poly_tone_synth dut_a (
        .clk               (clk),
        .resetn            (resetn),
        .note_valid        (note_valid),
        .note_idx          (note_idx),
        .note_dur          (note_dur),
        .all_off           (all_off),
        .mute              (mute),
        .audio_out_allowed (allowed),
        .write_audio_out   (a_write),
        .sample_out        (a_sample),
        .voices_active     (a_active),
        .sample_dropped    (a_dropped)
    );

    poly_tone_synth #(.SAMPLE_W(24)) dut_b (
        .clk               (clk),
        .resetn            (resetn),
        .note_valid        (note_valid),
        .note_idx          (note_idx),
        .note_dur          (note_dur),
        .all_off           (all_off),
        .mute              (mute),
        .audio_out_allowed (allowed),
        .write_audio_out   (b_write),
        .sample_out        (b_sample),
        .voices_active     (b_active),
        .sample_dropped    (b_dropped)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (a_write) seen = 1'b1;
        end
        check({tag, "_strobe"}, longint'(seen), 1);
    endtask

    task automatic trigger(input logic [3:0] idx, input logic [15:0] dur, input logic off);
        note_valid = 1'b1;
        note_idx   = idx;
        note_dur   = dur;
        all_off    = off;
        @(negedge clk);
        note_valid = 1'b0;
        note_idx   = '0;
        note_dur   = '0;
        all_off    = 1'b0;
    endtask

    task automatic check_first_tick(input string tag);
        int n = 0;
        while (!a_write && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 1042);
        check({tag, "_sample"}, longint'($signed(a_sample)), 0);
    endtask

    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        int unsigned t0;

        resetn     = 1'b0;
        note_valid = 1'b0;
        note_idx   = '0;
        note_dur   = '0;
        all_off    = 1'b0;
        mute       = 1'b0;
        allowed    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_write", a_write, 0);
        check("rst_sample", a_sample, 0);
        check("rst_active", a_active, 0);
        check("rst_dropped", a_dropped, 0);
        resetn = 1'b1;
        check_first_tick("first_tick");

        // Single voice, four-tick duration.
        trigger(4'd1, 16'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_strobe("dur", 1100);
            check("dur_a_sample", longint'($signed(a_sample)), AMP);
            check("dur_b_sample", longint'($signed(b_sample)), BMAX);
            check("dur_active", a_active, (k < 3) ? 1 : 0);
        end
        wait_strobe("dur_after", 1100);
        check("dur_after_sample", longint'($signed(a_sample)), 0);

        // Two voices on the same pitch, one cycle apart; exact half-period boundary.
        trigger(4'd1, 16'd0, 1'b0);
        t0 = cyc;
        trigger(4'd1, 16'd0, 1'b0);
        wait_strobe("pair", 1100);
        check("pair_a_sample", longint'($signed(a_sample)), 2 * AMP);
        check("pair_b_sample", longint'($signed(b_sample)), BMAX);
        check("pair_active", a_active, 4'b0011);
        while (cyc != t0 + 35768) @(negedge clk);
        check("phase0_before", dut_a.g_voice[0].u_voice.phase, 1);
        @(negedge clk);
        check("phase0_toggle", dut_a.g_voice[0].u_voice.phase, 0);
        check("phase1_before", dut_a.g_voice[1].u_voice.phase, 1);
        @(negedge clk);
        check("phase1_toggle", dut_a.g_voice[1].u_voice.phase, 0);
        wait_strobe("neg_skip", 1100);
        wait_strobe("neg", 1100);
        check("neg_a_sample", longint'($signed(a_sample)), -2 * AMP);
        check("neg_b_sample", longint'($signed(b_sample)), BMIN);

        mute = 1'b1;
        wait_strobe("mute", 1100);
        check("mute_a_sample", longint'($signed(a_sample)), 0);
        check("mute_b_sample", longint'($signed(b_sample)), 0);
        check("mute_active", a_active, 4'b0011);
        mute = 1'b0;

        // all_off beats a same-cycle trigger.
        trigger(4'd3, 16'd0, 1'b1);
        check("alloff_a_active", a_active, 0);
        check("alloff_b_active", b_active, 0);

        // Voice stealing.
        for (int i = 1; i <= 5; i++) trigger(4'(i), 16'd0, 1'b0);
        check("steal_active", a_active, 4'hF);
        check("steal_ptr", dut_a.alloc_ptr, 1);
        check("steal_v0_idx", dut_a.g_voice[0].u_voice.vs.idx, 5);
        check("steal_v1_idx", dut_a.g_voice[1].u_voice.vs.idx, 2);
        trigger(4'd0, 16'd7, 1'b0);
        check("rest_active", a_active, 4'hF);
        check("rest_ptr", dut_a.alloc_ptr, 1);
        check("rest_v1_idx", dut_a.g_voice[1].u_voice.vs.idx, 2);
        trigger(4'd0, 16'd0, 1'b1);
        check("release_active", a_active, 0);

        // Back-pressure: a silent sample is overwritten by a louder one.
        check("pre_dropped", a_dropped, 0);
        wait_strobe("bp_sync", 1100);
        allowed = 1'b0;
        strobes = 0;
        repeat (1041) begin
            @(negedge clk);
            if (a_write) strobes++;
        end
        trigger(4'd2, 16'd0, 1'b0);
        repeat (1042) begin
            @(negedge clk);
            if (a_write) strobes++;
        end
        check("bp_no_strobe", strobes, 0);
        check("bp_a_dropped", a_dropped, 1);
        check("bp_b_dropped", b_dropped, 1);
        allowed = 1'b1;
        wait_strobe("bp_release", 3);
        check("bp_a_sample", longint'($signed(a_sample)), AMP);
        check("bp_b_sample", longint'($signed(b_sample)), BMAX);
        check("bp_b_strobe", b_write, 1);
        @(negedge clk);
        check("bp_single", a_write, 0);
        check("bp_sticky", a_dropped, 1);

        // Asynchronous reset in the middle of a note.
        #5 resetn = 1'b0;
        #1;
        check("mid_rst_sample", a_sample, 0);
        check("mid_rst_active", a_active, 0);
        check("mid_rst_b_active", b_active, 0);
        check("mid_rst_write", a_write, 0);
        check("mid_rst_dropped", a_dropped, 0);
        @(negedge clk);
        resetn = 1'b1;
        check_first_tick("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
